// File: rtl/load_store_unit_pkg.sv
// -----------------------------------------------------------------------------
// load_store_unit_pkg
// Shared definitions for the load/store unit:
//   - RV32I funct3 width codes and the size field (funct3[1:0])
//   - FSM state encoding
//   - lane widths used by load extension and store merging
//   - helpers for funct3 legality and natural-alignment of the low address bits
// -----------------------------------------------------------------------------
package load_store_unit_pkg;

    // funct3 width codes
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Access size is carried in funct3[1:0]; funct3[2] selects zero-extension.
    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    // FSM state encoding
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_READ  = 2'd1;
    localparam logic [1:0] ST_WRITE = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    // Lane widths
    localparam int BYTE_W = 8;
    localparam int HALF_W = 16;
    localparam int WORD_W = 32;

    // Stores only have B/H/W encodings; loads additionally have BU/HU.
    function automatic logic f3_is_legal(input logic is_store, input logic [2:0] f3);
        logic ok;
        ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
        if (!is_store) begin
            ok = ok || (f3 == F3_BU) || (f3 == F3_HU);
        end
        return ok;
    endfunction

    // Clear the low address bits below the natural alignment of the access.
    function automatic logic [1:0] align_lo(input logic [1:0] size, input logic [1:0] lo);
        logic [1:0] res;
        case (size)
            SZ_B:    res = lo;
            SZ_H:    res = {lo[1], 1'b0};
            default: res = 2'b00;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// -----------------------------------------------------------------------------
// lsu_lane_align
// Combinational lane handling for the load/store unit.
//   i_funct3     : access width code (size in [1:0], zero-extend in [2])
//   i_addr_lo    : naturally aligned byte offset within the word
//   i_rd_word    : word read from data memory (load source)
//   i_old_word   : word previously read (store merge base)
//   i_wdata      : right-justified store data
//   o_load_data  : selected lane, sign/zero extended to 32 bits
//   o_store_word : i_old_word with the selected lane replaced (SW: i_wdata)
// -----------------------------------------------------------------------------
module lsu_lane_align
    import load_store_unit_pkg::*;
(
    input  logic [2:0]        i_funct3,
    input  logic [1:0]        i_addr_lo,
    input  logic [WORD_W-1:0] i_rd_word,
    input  logic [WORD_W-1:0] i_old_word,
    input  logic [WORD_W-1:0] i_wdata,
    output logic [WORD_W-1:0] o_load_data,
    output logic [WORD_W-1:0] o_store_word
);

    logic [BYTE_W-1:0] w_byte;
    logic [HALF_W-1:0] w_half;
    logic              w_byte_fill;
    logic              w_half_fill;

    assign w_byte      = i_rd_word[{i_addr_lo, 3'b000} +: BYTE_W];
    assign w_half      = i_rd_word[{i_addr_lo[1], 4'b0000} +: HALF_W];
    assign w_byte_fill = !i_funct3[2] && w_byte[BYTE_W-1];
    assign w_half_fill = !i_funct3[2] && w_half[HALF_W-1];

    // NOTE: every output of a combinational block gets a default before the
    // case so no path leaves it unassigned (which would infer a latch).
    always_comb begin
        o_load_data = i_rd_word;
        case (i_funct3[1:0])
            SZ_B:    o_load_data = {{(WORD_W-BYTE_W){w_byte_fill}}, w_byte};
            SZ_H:    o_load_data = {{(WORD_W-HALF_W){w_half_fill}}, w_half};
            default: ;
        endcase
    end

    always_comb begin
        o_store_word = i_old_word;
        case (i_funct3[1:0])
            SZ_B:    o_store_word[{i_addr_lo, 3'b000} +: BYTE_W]    = i_wdata[BYTE_W-1:0];
            SZ_H:    o_store_word[{i_addr_lo[1], 4'b0000} +: HALF_W] = i_wdata[HALF_W-1:0];
            default: o_store_word = i_wdata;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// -----------------------------------------------------------------------------
// load_store_unit
// Single-request load/store unit between a core and a word-wide data memory.
// Byte/halfword stores are done as read-modify-write.
//
// Ports:
//   CLK, RST      : clock, synchronous active-high reset
//   req, we       : request strobe (taken only when ready), 1 = store
//   funct3        : RV32I width code
//   addr, wdata   : byte address, right-justified store data
//   ready         : idle, can accept req
//   done, err     : one-cycle completion pulse, rejection flag (with done)
//   rdata         : extended load result, held until the next done
//   mem_RW        : data-memory write enable
//   mem_ADDr      : word-aligned data-memory byte address
//   mem_Din       : data-memory write word
//   mem_Dout      : data-memory read word (combinational)
//
// Configuration macro: LSU_MISALIGN_TRAP_EN
//   defined   : misaligned halfword/word accesses are rejected
//   undefined : low address bits are cleared to natural alignment
// -----------------------------------------------------------------------------
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int unsigned MEM_WORDS = 2001
)
(
    input  logic              CLK,
    input  logic              RST,
    input  logic              req,
    input  logic              we,
    input  logic [2:0]        funct3,
    input  logic [WORD_W-1:0] addr,
    input  logic [WORD_W-1:0] wdata,
    output logic              ready,
    output logic              done,
    output logic              err,
    output logic [WORD_W-1:0] rdata,
    output logic              mem_RW,
    output logic [WORD_W-1:0] mem_ADDr,
    output logic [WORD_W-1:0] mem_Din,
    input  logic [WORD_W-1:0] mem_Dout
);

    localparam logic [WORD_W:0] ADDR_LIMIT = (WORD_W+1)'(MEM_WORDS) * (WORD_W+1)'(4);

    logic [1:0]        r_state;
    logic              r_we;
    logic [2:0]        r_funct3;
    logic [1:0]        r_addr_lo;
    logic [WORD_W-1:0] r_wdata;
    logic [WORD_W-1:0] r_word;
    logic [WORD_W-1:0] r_rdata;
    logic [WORD_W-1:0] r_mem_addr;
    logic              r_err;

    logic              w_oor;
    logic              w_misalign;
    logic              w_reject;
    logic [WORD_W-1:0] w_load_data;
    logic [WORD_W-1:0] w_store_word;

    // ------------------------------------------------------------------
    // Request validation (evaluated on the incoming request in IDLE)
    // ------------------------------------------------------------------
    assign w_oor = {1'b0, addr} >= ADDR_LIMIT;

`ifdef LSU_MISALIGN_TRAP_EN
    assign w_misalign = ((funct3[1:0] == SZ_H) && addr[0]) ||
                        ((funct3[1:0] == SZ_W) && (addr[1:0] != 2'b00));
`else
    assign w_misalign = 1'b0;
`endif

    assign w_reject = !f3_is_legal(we, funct3) || w_oor || w_misalign;

    // ------------------------------------------------------------------
    // Control state
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state    <= ST_IDLE;
            r_err      <= 1'b0;
            r_rdata    <= '0;
            r_mem_addr <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (req) begin
                        r_err <= w_reject;
                        if (w_reject) begin
                            r_state <= ST_DONE;
                        end else begin
                            r_mem_addr <= {addr[WORD_W-1:2], 2'b00};
                            // Only a full-word store skips the read.
                            r_state    <= (we && (funct3[1:0] == SZ_W)) ? ST_WRITE : ST_READ;
                        end
                    end
                end
                ST_READ: begin
                    if (r_we) begin
                        r_state <= ST_WRITE;
                    end else begin
                        r_rdata <= w_load_data;
                        r_state <= ST_DONE;
                    end
                end
                ST_WRITE: r_state <= ST_DONE;
                ST_DONE:  r_state <= ST_IDLE;
                default:  r_state <= ST_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Request/data capture
    // ------------------------------------------------------------------
    // NOTE: pure datapath registers carry no reset; they are always loaded
    // before the control state lets anything read them.
    always_ff @(posedge CLK) begin
        if ((r_state == ST_IDLE) && req) begin
            r_we      <= we;
            r_funct3  <= funct3;
            r_addr_lo <= align_lo(funct3[1:0], addr[1:0]);
            r_wdata   <= wdata;
        end
        if (r_state == ST_READ) begin
            r_word <= mem_Dout;
        end
    end

    lsu_lane_align u_lane_align (
        .i_funct3     (r_funct3),
        .i_addr_lo    (r_addr_lo),
        .i_rd_word    (mem_Dout),
        .i_old_word   (r_word),
        .i_wdata      (r_wdata),
        .o_load_data  (w_load_data),
        .o_store_word (w_store_word)
    );

    // ------------------------------------------------------------------
    // Outputs. RST also gates them combinationally so that a reset landing
    // in WRITE blocks that cycle's memory write and the reset values show
    // from the first reset cycle.
    // ------------------------------------------------------------------
    assign ready    = (r_state == ST_IDLE) || RST;
    assign done     = (r_state == ST_DONE) && !RST;
    assign err      = done && r_err;
    assign rdata    = RST ? '0 : r_rdata;
    assign mem_RW   = (r_state == ST_WRITE) && !RST;
    assign mem_ADDr = RST ? '0 : r_mem_addr;
    assign mem_Din  = mem_RW ? w_store_word : '0;

endmodule

// File: tb/tb_load_store_unit.sv
// -----------------------------------------------------------------------------
// tb_load_store_unit
// Self-checking bench for load_store_unit with a behavioural data memory and
// a byte-level reference model of loads, stores and request rejection.
// -----------------------------------------------------------------------------
module tb_load_store_unit;

    localparam int MEM_WORDS = 2001;
    localparam int MEM_BYTES = MEM_WORDS * 4;
`ifdef LSU_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic        CLK;
    logic        RST;
    logic        req;
    logic        we;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        ready;
    logic        done;
    logic        err;
    logic [31:0] rdata;
    logic        mem_RW;
    logic [31:0] mem_ADDr;
    logic [31:0] mem_Din;
    logic [31:0] mem_Dout;

    int n_checks = 0;
    int n_fail   = 0;

    // data memory seen by the DUT, plus backdoor preload port
    logic [31:0] mem [MEM_WORDS];
    logic        bk_we;
    int          bk_idx;
    logic [31:0] bk_val;
    int          n_writes = 0;
    int          n_viol   = 0;

    // reference model state
    logic [31:0] ref_mem [MEM_WORDS];
    logic [31:0] ref_rdata = 32'h0;

    load_store_unit #(.MEM_WORDS(MEM_WORDS)) dut (
        .CLK      (CLK),
        .RST      (RST),
        .req      (req),
        .we       (we),
        .funct3   (funct3),
        .addr     (addr),
        .wdata    (wdata),
        .ready    (ready),
        .done     (done),
        .err      (err),
        .rdata    (rdata),
        .mem_RW   (mem_RW),
        .mem_ADDr (mem_ADDr),
        .mem_Din  (mem_Din),
        .mem_Dout (mem_Dout)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    always @(posedge CLK) begin
        if (mem_RW === 1'b1) begin
            n_writes <= n_writes + 1;
            if (int'(mem_ADDr[31:2]) < MEM_WORDS) mem[mem_ADDr[31:2]] <= mem_Din;
        end else if (bk_we) begin
            mem[bk_idx] <= bk_val;
        end
    end

    always_comb begin
        mem_Dout = 32'h0;
        if (mem_RW !== 1'b1 && int'(mem_ADDr[31:2]) < MEM_WORDS) mem_Dout = mem[mem_ADDr[31:2]];
    end

    // memory-port protocol monitor
    always @(negedge CLK) begin
        if (!RST) begin
            if (mem_ADDr[1:0] !== 2'b00) n_viol <= n_viol + 1;
            if (mem_RW !== 1'b1 && mem_Din !== 32'h0) n_viol <= n_viol + 1;
        end
    end

    // ------------------------------------------------------------------
    // helpers (drivers and model only; no comparisons)
    // ------------------------------------------------------------------
    task automatic bk_write(input int idx, input logic [31:0] val);
        bk_idx = idx; bk_val = val; bk_we = 1'b1;
        ref_mem[idx] = val;
        @(negedge CLK);
        bk_we = 1'b0;
    endtask

    // Called at a negedge with the DUT idle; returns at a negedge, idle again.
    task automatic do_access(input logic w, input logic [2:0] f3, input logic [31:0] a,
                             input logic [31:0] wd, output int lat, output logic e,
                             output logic [31:0] rd, output logic d_after);
        req = 1'b1; we = w; funct3 = f3; addr = a; wdata = wd;
        @(posedge CLK);
        @(negedge CLK);
        req = 1'b0; we = 1'b0; funct3 = 3'b000; addr = 32'h0; wdata = 32'h0;
        lat = 1;
        while (done !== 1'b1 && lat < 8) begin
            @(negedge CLK);
            lat++;
        end
        e  = err;
        rd = rdata;
        @(negedge CLK);
        d_after = done;
    endtask

    // Byte-level reference: returns expected err and latency, updates
    // ref_mem for stores and ref_rdata for successful loads.
    task automatic ref_access(input logic w, input logic [2:0] f3, input logic [31:0] a,
                              input logic [31:0] wd, output logic e, output int lat);
        int          size;
        logic        legal;
        logic [31:0] ea;
        int          widx;
        int          boff;
        logic [31:0] word;
        logic [31:0] mask;
        logic [31:0] val;
        size  = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
        legal = w ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        e     = !legal || (a >= 32'(MEM_BYTES)) || (TRAP && (a % 32'(size) != 0));
        lat   = 1;
        if (e) return;
        ea   = a - (a % 32'(size));
        widx = int'(ea / 4);
        boff = int'(ea % 4);
        word = ref_mem[widx];
        if (!w) begin
            if (size == 4) begin
                val = word;
            end else begin
                mask = (32'd1 << (8 * size)) - 32'd1;
                val  = (word >> (8 * boff)) & mask;
                if (!f3[2] && val[8*size-1]) val = val | ~mask;
            end
            ref_rdata = val;
            lat = 2;
        end else begin
            for (int i = 0; i < size; i++) word[8*(boff+i) +: 8] = wd[8*i +: 8];
            ref_mem[widx] = word;
            lat = (size == 4) ? 2 : 3;
        end
    endtask

    // ------------------------------------------------------------------
    // tests
    // ------------------------------------------------------------------
    task automatic test_reset();
        n_checks++; if (ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", ready); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
        n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", err); end
        n_checks++; if (rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata: got %h want 0", rdata); end
        n_checks++; if (mem_RW !== 1'b0) begin n_fail++; $display("FAIL reset_mem_RW: got %b want 0", mem_RW); end
        n_checks++; if (mem_ADDr !== 32'h0) begin n_fail++; $display("FAIL reset_mem_ADDr: got %h want 0", mem_ADDr); end
        n_checks++; if (mem_Din !== 32'h0) begin n_fail++; $display("FAIL reset_mem_Din: got %h want 0", mem_Din); end
    endtask

    task automatic test_load_extend();
        int lat; logic e; logic [31:0] rd; logic da; logic re; int rl;
        bk_write(16, 32'h8899AABB);
        do_access(1'b0, 3'b000, 32'h43, 32'h0, lat, e, rd, da);
        ref_access(1'b0, 3'b000, 32'h43, 32'h0, re, rl);
        n_checks++; if (lat !== 2) begin n_fail++; $display("FAIL lb_latency: got %0d want 2", lat); end
        n_checks++; if (e !== 1'b0) begin n_fail++; $display("FAIL lb_err: got %b want 0", e); end
        n_checks++; if (rd !== 32'hFFFFFF88) begin n_fail++; $display("FAIL lb_rdata: got %h want ffffff88", rd); end
        n_checks++; if (da !== 1'b0) begin n_fail++; $display("FAIL lb_done_width: done still %b", da); end
        do_access(1'b0, 3'b101, 32'h42, 32'h0, lat, e, rd, da);
        ref_access(1'b0, 3'b101, 32'h42, 32'h0, re, rl);
        n_checks++; if (rd !== 32'h00008899) begin n_fail++; $display("FAIL lhu_rdata: got %h want 00008899", rd); end
        do_access(1'b0, 3'b001, 32'h42, 32'h0, lat, e, rd, da);
        ref_access(1'b0, 3'b001, 32'h42, 32'h0, re, rl);
        n_checks++; if (rd !== 32'hFFFF8899) begin n_fail++; $display("FAIL lh_rdata: got %h want ffff8899", rd); end
    endtask

    task automatic test_store_byte();
        int lat; logic e; logic [31:0] rd; logic da; logic re; int rl;
        bk_write(16, 32'h11223344);
        do_access(1'b1, 3'b000, 32'h41, 32'hFFFFFFAB, lat, e, rd, da);
        ref_access(1'b1, 3'b000, 32'h41, 32'hFFFFFFAB, re, rl);
        n_checks++; if (lat !== 3) begin n_fail++; $display("FAIL sb_latency: got %0d want 3", lat); end
        n_checks++; if (e !== 1'b0) begin n_fail++; $display("FAIL sb_err: got %b want 0", e); end
        do_access(1'b0, 3'b010, 32'h40, 32'h0, lat, e, rd, da);
        ref_access(1'b0, 3'b010, 32'h40, 32'h0, re, rl);
        n_checks++; if (lat !== 2) begin n_fail++; $display("FAIL lw_latency: got %0d want 2", lat); end
        n_checks++; if (rd !== 32'h1122AB44) begin n_fail++; $display("FAIL sb_merge: got %h want 1122ab44", rd); end
    endtask

    task automatic test_out_of_range();
        int lat; logic e; logic [31:0] rd; logic da; logic re; int rl; int wc;
        wc = n_writes;
        do_access(1'b0, 3'b010, 32'h1F44, 32'h0, lat, e, rd, da);
        ref_access(1'b0, 3'b010, 32'h1F44, 32'h0, re, rl);
        n_checks++; if (lat !== 1) begin n_fail++; $display("FAIL oor_latency: got %0d want 1", lat); end
        n_checks++; if (e !== 1'b1) begin n_fail++; $display("FAIL oor_err: got %b want 1", e); end
        n_checks++; if (rd !== 32'h1122AB44) begin n_fail++; $display("FAIL oor_rdata_held: got %h want 1122ab44", rd); end
        do_access(1'b1, 3'b010, 32'h1F44, 32'h12345678, lat, e, rd, da);
        ref_access(1'b1, 3'b010, 32'h1F44, 32'h12345678, re, rl);
        n_checks++; if (e !== 1'b1) begin n_fail++; $display("FAIL oor_store_err: got %b want 1", e); end
        n_checks++; if (n_writes !== wc) begin n_fail++; $display("FAIL oor_no_write: got %0d writes want 0", n_writes - wc); end
        do_access(1'b0, 3'b010, 32'h1F40, 32'h0, lat, e, rd, da);
        ref_access(1'b0, 3'b010, 32'h1F40, 32'h0, re, rl);
        n_checks++; if (e !== 1'b0 || rd !== ref_mem[2000]) begin
            n_fail++; $display("FAIL last_word: got err=%b %h want err=0 %h", e, rd, ref_mem[2000]); end
        do_access(1'b0, 3'b011, 32'h40, 32'h0, lat, e, rd, da);
        ref_access(1'b0, 3'b011, 32'h40, 32'h0, re, rl);
        n_checks++; if (e !== 1'b1 || lat !== 1) begin
            n_fail++; $display("FAIL illegal_f3: got err=%b lat=%0d want err=1 lat=1", e, lat); end
    endtask

    task automatic test_misalign();
        int lat; logic e; logic [31:0] rd; logic da; logic re; int rl;
        logic [31:0] exp_word;
        bk_write(16, 32'h11223344);
        do_access(1'b1, 3'b010, 32'h42, 32'hDEADBEEF, lat, e, rd, da);
        ref_access(1'b1, 3'b010, 32'h42, 32'hDEADBEEF, re, rl);
        exp_word = TRAP ? 32'h11223344 : 32'hDEADBEEF;
        n_checks++; if (e !== TRAP) begin n_fail++; $display("FAIL misalign_sw_err: got %b want %b", e, TRAP); end
        n_checks++; if (mem[16] !== exp_word) begin n_fail++; $display("FAIL misalign_sw_mem: got %h want %h", mem[16], exp_word); end
        do_access(1'b0, 3'b001, 32'h43, 32'h0, lat, e, rd, da);
        ref_access(1'b0, 3'b001, 32'h43, 32'h0, re, rl);
        n_checks++; if (e !== re || lat !== rl || rd !== ref_rdata) begin
            n_fail++; $display("FAIL misalign_lh: got err=%b lat=%0d %h want err=%b lat=%0d %h", e, lat, rd, re, rl, ref_rdata); end
    endtask

    task automatic test_reset_abort();
        int lat; logic e; logic [31:0] rd; logic da; logic re; int rl;
        logic seen_done;
        bk_write(4, 32'hCAFEF00D);
        req = 1'b1; we = 1'b1; funct3 = 3'b001; addr = 32'h10; wdata = 32'h00001234;
        @(posedge CLK);
        @(negedge CLK);
        req = 1'b0; we = 1'b0;
        seen_done = done;
        @(posedge CLK);
        @(negedge CLK);
        n_checks++; if (mem_RW !== 1'b1) begin n_fail++; $display("FAIL sh_in_write: mem_RW got %b want 1", mem_RW); end
        RST = 1'b1;
        #1;
        n_checks++; if (mem_RW !== 1'b0) begin n_fail++; $display("FAIL abort_mem_RW: got %b want 0", mem_RW); end
        @(posedge CLK);
        @(negedge CLK);
        RST = 1'b0;
        ref_rdata = 32'h0;
        seen_done = seen_done | done;
        #1;
        n_checks++; if (mem_RW !== 1'b0) begin n_fail++; $display("FAIL abort_after_mem_RW: got %b want 0", mem_RW); end
        n_checks++; if (ready !== 1'b1) begin n_fail++; $display("FAIL abort_ready: got %b want 1", ready); end
        n_checks++; if (rdata !== 32'h0) begin n_fail++; $display("FAIL abort_rdata: got %h want 0", rdata); end
        @(negedge CLK);
        seen_done = seen_done | done;
        n_checks++; if (seen_done !== 1'b0) begin n_fail++; $display("FAIL abort_done: got %b want 0", seen_done); end
        n_checks++; if (mem[4] !== 32'hCAFEF00D) begin n_fail++; $display("FAIL abort_mem: got %h want cafef00d", mem[4]); end
        do_access(1'b0, 3'b010, 32'h10, 32'h0, lat, e, rd, da);
        ref_access(1'b0, 3'b010, 32'h10, 32'h0, re, rl);
        n_checks++; if (lat !== 2 || e !== 1'b0 || rd !== 32'hCAFEF00D) begin
            n_fail++; $display("FAIL post_abort_lw: got lat=%0d err=%b %h want lat=2 err=0 cafef00d", lat, e, rd); end
    endtask

    task automatic test_req_in_done();
        logic re; int rl; int wc; int cyc;
        req = 1'b1; we = 1'b0; funct3 = 3'b010; addr = 32'h40; wdata = 32'h0;
        ref_access(1'b0, 3'b010, 32'h40, 32'h0, re, rl);
        @(posedge CLK);
        @(negedge CLK);
        req = 1'b0;
        cyc = 0;
        while (done !== 1'b1 && cyc < 8) begin @(negedge CLK); cyc++; end
        n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL rid_done: got %b want 1", done); end
        wc = n_writes;
        req = 1'b1; we = 1'b1; funct3 = 3'b010; addr = 32'h80; wdata = 32'h55AA55AA;
        @(posedge CLK);
        @(negedge CLK);
        req = 1'b0; we = 1'b0;
        n_checks++; if (ready !== 1'b1 || done !== 1'b0) begin
            n_fail++; $display("FAIL rid_ignored: got ready=%b done=%b want 1 0", ready, done); end
        repeat (3) @(negedge CLK);
        n_checks++; if (n_writes !== wc || mem[32] !== ref_mem[32]) begin
            n_fail++; $display("FAIL rid_no_store: got %0d writes %h want 0 %h", n_writes - wc, mem[32], ref_mem[32]); end
    endtask

    task automatic test_random();
        int lat; logic e; logic [31:0] rd; logic da; logic re; int rl;
        logic w; logic [2:0] f3; logic [31:0] a; logic [31:0] wd; int sel;
        for (int n = 0; n < 400; n++) begin
            w  = $urandom_range(0, 1) == 1;
            f3 = w ? 3'($urandom_range(0, 3)) : 3'($urandom_range(0, 7));
            sel = $urandom_range(0, 9);
            if (sel <= 5)      a = 32'($urandom_range(0, 255));
            else if (sel <= 7) a = 32'(MEM_BYTES - 8 + $urandom_range(0, 15));
            else if (sel == 8) a = $urandom;
            else               a = 32'($urandom_range(0, MEM_BYTES - 1));
            wd = $urandom;
            n_checks++; if (ready !== 1'b1) begin n_fail++; $display("FAIL rnd_ready[%0d]: got %b want 1", n, ready); end
            do_access(w, f3, a, wd, lat, e, rd, da);
            ref_access(w, f3, a, wd, re, rl);
            n_checks++; if (e !== re) begin
                n_fail++; $display("FAIL rnd_err[%0d] we=%b f3=%0d a=%h: got %b want %b", n, w, f3, a, e, re); end
            n_checks++; if (lat !== rl) begin
                n_fail++; $display("FAIL rnd_latency[%0d] we=%b f3=%0d a=%h: got %0d want %0d", n, w, f3, a, lat, rl); end
            n_checks++; if (rd !== ref_rdata) begin
                n_fail++; $display("FAIL rnd_rdata[%0d] we=%b f3=%0d a=%h: got %h want %h", n, w, f3, a, rd, ref_rdata); end
            n_checks++; if (da !== 1'b0) begin n_fail++; $display("FAIL rnd_done_width[%0d]: done still %b", n, da); end
        end
    endtask

    task automatic test_memory_image();
        int bad; int first;
        bad = 0; first = -1;
        for (int i = 0; i < MEM_WORDS; i++) begin
            if (mem[i] !== ref_mem[i]) begin
                bad++;
                if (first < 0) first = i;
            end
        end
        n_checks++; if (bad !== 0) begin
            n_fail++; $display("FAIL memory_image: got %0d differing words (first %0d) want 0", bad, first); end
        n_checks++; if (n_viol !== 0) begin
            n_fail++; $display("FAIL mem_port_protocol: got %0d violations want 0", n_viol); end
    endtask

    initial begin
        RST = 1'b1; req = 1'b0; we = 1'b0; funct3 = 3'b000; addr = 32'h0; wdata = 32'h0;
        bk_we = 1'b0; bk_idx = 0; bk_val = 32'h0;
        repeat (3) @(negedge CLK);
        test_reset();
        RST = 1'b0;
        for (int i = 0; i < MEM_WORDS; i++) bk_write(i, $urandom);
        test_load_extend();
        test_store_byte();
        test_out_of_range();
        test_misalign();
        test_reset_abort();
        test_req_in_done();
        test_random();
        test_memory_image();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
